mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
//  Far end of the CPU byte-wide memory bus (mem_a/mem_dout/mem_wr in, mem_din/io_buffer_full out).
//  Holds the 128KB RAM, decodes I/O space (addr[17:16]==2'b11) and serves the UART tx/rx byte
//  streams plus the cycle counter. Sits between the cpu top and the UART/host interface.
// PARAMETERS
//  RAM_ADDR_WIDTH  17  byte address bits of RAM (2^17 = 128KB)
//  TX_FIFO_WIDTH   3   log2 depth of tx byte FIFO (8 entries)
//  RX_FIFO_WIDTH   3   log2 depth of rx byte FIFO (8 entries)
//  FULL_MARGIN     2   io_buffer_full asserted when free tx slots <= FULL_MARGIN
// PORTS
//  clk_in          in   1   system clock
//  rst_in          in   1   synchronous reset, active-high
//  rdy_in          in   1   system ready; bus access and counter frozen when low
//  mem_a           in   32  CPU address; only [17:0] decoded
//  mem_wdata       in   8   CPU write byte (cpu mem_dout)
//  mem_wr          in   1   1 = write, 0 = read
//  mem_rdata       out  8   read byte (cpu mem_din), valid cycle after address
//  io_buffer_full  out  1   tx FIFO near full; CPU must hold off I/O writes
//  uart_tx_valid   out  1   tx FIFO non-empty
//  uart_tx_data    out  8   tx FIFO head byte
//  uart_tx_ready   in   1   UART pops head when valid && ready
//  uart_rx_valid   in   1   incoming byte strobe
//  uart_rx_data    in   8   incoming byte
//  program_done    out  1   sticky; set by write to 0x30004
// BEHAVIOUR
//  - Reset: mem_rdata=0, io_buffer_full=0, uart_tx_valid=0, program_done=0, counter=0,
//    snapshot=0, both FIFOs empty. RAM contents not reset.
//  - Access fires on cycle with rdy_in=1. rdy_in=0: no RAM write, no FIFO push/pop by bus,
//    mem_rdata holds, counter holds; UART side (tx pop, rx push) keeps running.
//  - RAM (addr[17:16]!=2'b11): write stores mem_wdata at addr[RAM_ADDR_WIDTH-1:0] same edge;
//    read registers byte into mem_rdata next edge (1-cycle latency). Read-after-write same
//    address on next cycle returns new byte.
//  - I/O decode on addr[2:0] with addr[17:16]==2'b11:
//    0x30000 rd: pop rx FIFO, mem_rdata=head; empty -> mem_rdata=0x00, no pop.
//    0x30000 wr: push mem_wdata to tx FIFO; 0x00 ignored; push when tx full is dropped.
//    0x30004..7 rd: byte addr[1:0] of snapshot (little-endian). Read of 0x30004 returns
//      counter[7:0] live and loads snapshot<=counter, so 0x30005..7 give coherent upper bytes.
//    0x30004 wr: push 0x00 into tx FIFO (bypasses zero filter), set program_done.
//    Other I/O addresses: read 0x00, write ignored.
//  - Counter: 32-bit, +1 each cycle rdy_in=1 after reset, wraps 0xFFFFFFFF -> 0.
//  - io_buffer_full registered: 1 when (TX_DEPTH - count) <= FULL_MARGIN after this edge's
//    push/pop; margin covers in-flight CPU writes.
//  - Tx push and UART pop same cycle: count unchanged; allowed even when full (pop first).
//  - Rx push when rx full: byte dropped. Rx push and bus pop same cycle: both honoured.
//  - Pointers wrap modulo depth; count width is FIFO_WIDTH+1.
//  - program_done sticky until rst_in; reset mid-stream clears FIFOs, in-flight byte lost.
// STRUCTURE
//  - Package mem_io_pkg: IO_BASE_HI=2'b11, ADDR_UART=3'h0, ADDR_CLK=3'h4, counter width.
//  - Sub-module byte_fifo #(WIDTH): push/pop/din/dout/empty/full/count; instantiated for tx, rx.
//  - Top: RAM array, address decode, counter+snapshot, mem_rdata register, full flag.
// TESTING
//  - RAM: wr 0x1234<-0xA5, rd 0x1234 next cycle -> mem_rdata=0xA5 one cycle after read addr.
//  - UART out: wr 0x30000 bytes 0x48,0x00,0x69 -> tx stream 0x48,0x69 only; pop with ready=1.
//  - Full: uart_tx_ready=0, push 6 bytes (depth 8) -> io_buffer_full=1 after 6th; 9th dropped.
//  - Counter: after 100 rdy cycles rd 0x30004..7 -> bytes form value matching snapshot at
//    0x30004 read; rdy_in=0 for 10 cycles -> counter unchanged.
//  - Rx: push 0x31,0x32; rd 0x30000 twice -> 0x31,0x32; third rd -> 0x00.
//  - Stop: wr 0x30004 -> program_done=1, tx emits 0x00; rst_in mid-tx -> all outputs reset.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared decode constants and the address-space classifier for the memory/IO responder.
package mem_io_pkg;

   localparam logic [1:0] IO_BASE_HI = 2'b11;
   localparam logic [2:0] ADDR_UART  = 3'h0;
   localparam logic [2:0] ADDR_CLK   = 3'h4;
   localparam int         CNT_W      = 32;

   typedef enum logic [1:0] {
      SEL_RAM,
      SEL_UART,
      SEL_CLK,
      SEL_NONE
   } io_sel_e;

   // 0x30004..7 all map to the counter window; 0x30001..3 are unused holes.
   function automatic io_sel_e decode_sel(input logic [1:0] hi, input logic [2:0] lo);
      if (hi != IO_BASE_HI) return SEL_RAM;
      if (lo == ADDR_UART)  return SEL_UART;
      if (lo[2])            return SEL_CLK;
      return SEL_NONE;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO, 2**WIDTH entries. A pop frees a slot for a push on the same edge.
module byte_fifo #(
   parameter int WIDTH = 3
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           push_i,
   input  logic           pop_i,
   input  logic [7:0]     din_i,
   output logic [7:0]     dout_o,
   output logic           empty_o,
   output logic           full_o,
   output logic [WIDTH:0] count_o,
   output logic [WIDTH:0] count_nxt_o
);

   localparam int DEPTH = 1 << WIDTH;

   logic [7:0]       mem_q [DEPTH];
   logic [WIDTH-1:0] wr_q, rd_q;
   logic [WIDTH:0]   cnt_q, cnt_d;
   logic             push_eff, pop_eff;

   assign empty_o     = (cnt_q == '0);
   assign full_o      = (cnt_q == (WIDTH+1)'(DEPTH));
   assign dout_o      = mem_q[rd_q];
   assign count_o     = cnt_q;
   assign count_nxt_o = cnt_d;

   assign pop_eff  = pop_i && !empty_o;
   assign push_eff = push_i && (!full_o || pop_eff);

   always_comb begin
      cnt_d = cnt_q;
      case ({push_eff, pop_eff})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push_eff) mem_q[wr_q] <= din_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_eff) wr_q <= wr_q + 1'b1;
         if (pop_eff)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_io_responder.sv
// Far end of the CPU byte bus: 128KB RAM, UART tx/rx byte FIFOs, free-running cycle counter
// with a coherent 32-bit snapshot, and the sticky program_done flag.
module mem_io_responder #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int TX_FIFO_WIDTH  = 3,
   parameter int RX_FIFO_WIDTH  = 3,
   parameter int FULL_MARGIN    = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_wdata,
   input  logic        mem_wr,
   output logic [7:0]  mem_rdata,
   output logic        io_buffer_full,
   output logic        uart_tx_valid,
   output logic [7:0]  uart_tx_data,
   input  logic        uart_tx_ready,
   input  logic        uart_rx_valid,
   input  logic [7:0]  uart_rx_data,
   output logic        program_done
);

   import mem_io_pkg::*;

   localparam int TX_DEPTH = 1 << TX_FIFO_WIDTH;

   logic [7:0]                ram_q [2**RAM_ADDR_WIDTH];
   logic [RAM_ADDR_WIDTH-1:0] ram_addr;
   logic [7:0]                ram_dout_q;
   logic                      ram_we, ram_re;

   io_sel_e    sel;
   logic       rd_src_q, rd_src_d;
   logic [7:0] rdata_q, rdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, snap_q, snap_d;
   logic       done_q, done_d, full_q, full_d;

   logic       tx_push, tx_empty, rx_pop, rx_empty;
   logic [7:0] tx_din, rx_dout;
   logic [TX_FIFO_WIDTH:0] tx_cnt_nxt, unused_tx_cnt;
   logic [RX_FIFO_WIDTH:0] unused_rx_cnt, unused_rx_cnt_nxt;
   logic       unused_tx_full, unused_rx_full, unused_addr;

   assign unused_addr = ^mem_a[31:18];
   assign ram_addr    = mem_a[RAM_ADDR_WIDTH-1:0];
   assign sel         = decode_sel(mem_a[17:16], mem_a[2:0]);

   always_comb begin
      tx_push  = 1'b0;
      tx_din   = mem_wdata;
      rx_pop   = 1'b0;
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      rd_src_d = rd_src_q;
      rdata_d  = rdata_q;
      snap_d   = snap_q;
      done_d   = done_q;
      if (rdy_in) begin
         case (sel)
            SEL_RAM: begin
               ram_we = mem_wr;
               if (!mem_wr) begin
                  ram_re   = 1'b1;
                  rd_src_d = 1'b1;
               end
            end
            SEL_UART: begin
               if (mem_wr) begin
                  tx_push = (mem_wdata != 8'h00);
               end else begin
                  rx_pop   = !rx_empty;
                  rd_src_d = 1'b0;
                  rdata_d  = rx_empty ? 8'h00 : rx_dout;
               end
            end
            SEL_CLK: begin
               if (mem_wr) begin
                  // Stop marker: a literal zero byte that the data-path filter would drop.
                  if (mem_a[1:0] == 2'b00) begin
                     tx_push = 1'b1;
                     tx_din  = 8'h00;
                     done_d  = 1'b1;
                  end
               end else begin
                  rd_src_d = 1'b0;
                  if (mem_a[1:0] == 2'b00) begin
                     rdata_d = cnt_q[7:0];
                     snap_d  = cnt_q;
                  end else begin
                     rdata_d = snap_q[{mem_a[1:0], 3'b000} +: 8];
                  end
               end
            end
            default: begin
               if (!mem_wr) begin
                  rd_src_d = 1'b0;
                  rdata_d  = 8'h00;
               end
            end
         endcase
      end
   end

   assign cnt_d  = rdy_in ? cnt_q + 1'b1 : cnt_q;
   assign full_d = (TX_DEPTH - int'(tx_cnt_nxt)) <= FULL_MARGIN;

   // RAM kept in its own reset-free process so it maps onto block memory.
   always_ff @(posedge clk_in) begin
      if (ram_we) ram_q[ram_addr] <= mem_wdata;
      if (ram_re) ram_dout_q <= ram_q[ram_addr];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_src_q <= 1'b0;
         rdata_q  <= 8'h00;
         cnt_q    <= '0;
         snap_q   <= '0;
         done_q   <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         rd_src_q <= rd_src_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
         snap_q   <= snap_d;
         done_q   <= done_d;
         full_q   <= full_d;
      end
   end

   assign mem_rdata      = rd_src_q ? ram_dout_q : rdata_q;
   assign io_buffer_full = full_q;
   assign program_done   = done_q;
   assign uart_tx_valid  = !tx_empty;

   byte_fifo #(.WIDTH(TX_FIFO_WIDTH)) u_tx_fifo (
      .clk_i       (clk_in),
      .rst_i       (rst_in),
      .push_i      (tx_push),
      .pop_i       (uart_tx_ready),
      .din_i       (tx_din),
      .dout_o      (uart_tx_data),
      .empty_o     (tx_empty),
      .full_o      (unused_tx_full),
      .count_o     (unused_tx_cnt),
      .count_nxt_o (tx_cnt_nxt)
   );

   byte_fifo #(.WIDTH(RX_FIFO_WIDTH)) u_rx_fifo (
      .clk_i       (clk_in),
      .rst_i       (rst_in),
      .push_i      (uart_rx_valid),
      .pop_i       (rx_pop),
      .din_i       (uart_rx_data),
      .dout_o      (rx_dout),
      .empty_o     (rx_empty),
      .full_o      (unused_rx_full),
      .count_o     (unused_rx_cnt),
      .count_nxt_o (unused_rx_cnt_nxt)
   );

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenario tasks plus a randomized run against a
// queue-based model of the bus, FIFOs and counter.
module tb_mem_io_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic [31:0] mem_a = '0;
   logic [7:0]  mem_wdata = '0;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_rdata;
   logic        io_buffer_full, uart_tx_valid, program_done;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_ready = 1'b0;
   logic        uart_rx_valid = 1'b0;
   logic [7:0]  uart_rx_data = '0;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [7:0]  m_ram [int];
   logic [7:0]  m_tx [$];
   logic [7:0]  m_rx [$];
   int unsigned m_cnt, m_snap;
   logic [7:0]  m_rdata;
   logic        m_full, m_done;

   mem_io_responder dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .rdy_in         (rdy),
      .mem_a          (mem_a),
      .mem_wdata      (mem_wdata),
      .mem_wr         (mem_wr),
      .mem_rdata      (mem_rdata),
      .io_buffer_full (io_buffer_full),
      .uart_tx_valid  (uart_tx_valid),
      .uart_tx_data   (uart_tx_data),
      .uart_tx_ready  (uart_tx_ready),
      .uart_rx_valid  (uart_rx_valid),
      .uart_rx_data   (uart_rx_data),
      .program_done   (program_done)
   );

   always #5 clk = ~clk;

   // Advance one clock, applying the bus/UART rules to the model with the current inputs.
   task automatic step();
      logic [17:0] a;
      a = mem_a[17:0];
      if (rst) begin
         m_tx.delete(); m_rx.delete();
         m_cnt = 0; m_snap = 0; m_rdata = 8'h00; m_full = 1'b0; m_done = 1'b0;
      end else begin
         if (uart_tx_ready && m_tx.size() > 0) void'(m_tx.pop_front());
         if (rdy) begin
            if (a[17:16] != 2'b11) begin
               if (mem_wr) m_ram[int'(a[16:0])] = mem_wdata;
               else        m_rdata = m_ram[int'(a[16:0])];
            end else if (a[2:0] == 3'd0) begin
               if (mem_wr) begin
                  if (mem_wdata != 8'h00 && m_tx.size() < 8) m_tx.push_back(mem_wdata);
               end else if (m_rx.size() > 0) m_rdata = m_rx.pop_front();
               else m_rdata = 8'h00;
            end else if (a[2]) begin
               if (mem_wr) begin
                  if (a[1:0] == 2'd0) begin
                     if (m_tx.size() < 8) m_tx.push_back(8'h00);
                     m_done = 1'b1;
                  end
               end else if (a[1:0] == 2'd0) begin
                  m_rdata = m_cnt[7:0];
                  m_snap  = m_cnt;
               end else m_rdata = 8'((m_snap >> (8 * a[1:0])) & 32'hFF);
            end else if (!mem_wr) m_rdata = 8'h00;
         end
         if (uart_rx_valid && m_rx.size() < 8) m_rx.push_back(uart_rx_data);
         if (rdy) m_cnt = m_cnt + 1;
         m_full = (8 - m_tx.size()) <= 2;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
      mem_a = a; mem_wr = w; mem_wdata = d;
      step();
      mem_a = '0; mem_wr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; rdy = 1'b1; uart_tx_ready = 1'b0; uart_rx_valid = 1'b0;
      mem_a = '0; mem_wr = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (mem_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", mem_rdata); end
      total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", io_buffer_full); end
      total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_txv got=%b exp=0", uart_tx_valid); end
      total++; if (program_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", program_done); end
      bus(32'h30004, 1'b0, 8'h00);
      total++; if (mem_rdata !== 8'h00) begin bad++; $display("FAIL reset_cnt got=%h exp=00", mem_rdata); end
      bus(32'h0, 1'b1, 8'h00);  // keeps idle reads of address 0 defined
   endtask

   task automatic test_ram();
      do_reset();
      bus(32'h1234, 1'b1, 8'hA5);
      bus(32'h1234, 1'b0, 8'h00);
      total++; if (mem_rdata !== 8'hA5) begin bad++; $display("FAIL ram_rd got=%h exp=a5", mem_rdata); end
      bus(32'h1235, 1'b1, 8'h5A);
      total++; if (mem_rdata !== 8'hA5) begin bad++; $display("FAIL ram_wr_hold got=%h exp=a5", mem_rdata); end
      bus(32'h1235, 1'b0, 8'h00);
      total++; if (mem_rdata !== 8'h5A) begin bad++; $display("FAIL ram_rd2 got=%h exp=5a", mem_rdata); end
      bus(32'h1FFFF, 1'b1, 8'hC3);
      bus(32'hFFF1FFFF, 1'b0, 8'h00);
      total++; if (mem_rdata !== 8'hC3) begin bad++; $display("FAIL ram_top got=%h exp=c3", mem_rdata); end
   endtask

   task automatic test_uart_tx();
      logic [7:0] got [$];
      do_reset();
      bus(32'h30000, 1'b1, 8'h48);
      bus(32'h30000, 1'b1, 8'h00);
      bus(32'h30000, 1'b1, 8'h69);
      total++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h48) begin
         bad++; $display("FAIL tx_head got=%b/%h exp=1/48", uart_tx_valid, uart_tx_data); end
      uart_tx_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (uart_tx_valid) got.push_back(uart_tx_data);
         step();
      end
      uart_tx_ready = 1'b0;
      total++; if (got.size() != 2) begin bad++; $display("FAIL tx_len got=%0d exp=2", got.size()); end
      else begin
         total++; if (got[0] !== 8'h48 || got[1] !== 8'h69) begin
            bad++; $display("FAIL tx_stream got=%h,%h exp=48,69", got[0], got[1]); end
      end
   endtask

   task automatic test_full();
      logic [7:0] got [$];
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         bus(32'h30000, 1'b1, 8'(i));
         if (i == 5) begin
            total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL full_at5 got=%b exp=0", io_buffer_full); end
         end
      end
      total++; if (io_buffer_full !== 1'b1) begin bad++; $display("FAIL full_at6 got=%b exp=1", io_buffer_full); end
      bus(32'h30000, 1'b1, 8'h07);
      bus(32'h30000, 1'b1, 8'h08);
      bus(32'h30000, 1'b1, 8'h99);  // dropped: FIFO holds 8
      uart_tx_ready = 1'b1;
      bus(32'h30000, 1'b1, 8'h09);  // pop and push together at full
      total++; if (io_buffer_full !== 1'b1) begin bad++; $display("FAIL full_pp got=%b exp=1", io_buffer_full); end
      for (int i = 0; i < 12; i++) begin
         if (uart_tx_valid) got.push_back(uart_tx_data);
         step();
      end
      uart_tx_ready = 1'b0;
      total++; if (got.size() != 8) begin bad++; $display("FAIL full_len got=%0d exp=8", got.size()); end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         total++; if (got[i] !== 8'(i + 2)) begin bad++; $display("FAIL full_data[%0d] got=%h exp=%h", i, got[i], 8'(i + 2)); end
      end
      total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL full_drained got=%b exp=0", io_buffer_full); end
   endtask

   task automatic test_counter();
      logic [31:0] v;
      do_reset();
      for (int i = 0; i < 100; i++) step();
      bus(32'h30004, 1'b0, 8'h00); v[7:0]   = mem_rdata;
      bus(32'h30005, 1'b0, 8'h00); v[15:8]  = mem_rdata;
      bus(32'h30006, 1'b0, 8'h00); v[23:16] = mem_rdata;
      bus(32'h30007, 1'b0, 8'h00); v[31:24] = mem_rdata;
      total++; if (v !== 32'd100) begin bad++; $display("FAIL cnt_snap got=%0d exp=100", v); end
      bus(32'h30004, 1'b0, 8'h00);
      total++; if (mem_rdata !== 8'd104) begin bad++; $display("FAIL cnt_live got=%0d exp=104", mem_rdata); end
      rdy = 1'b0;
      mem_a = 32'h30006;
      for (int i = 0; i < 10; i++) step();
      total++; if (mem_rdata !== 8'd104) begin bad++; $display("FAIL cnt_hold_rdata got=%0d exp=104", mem_rdata); end
      bus(32'h30000, 1'b1, 8'h33);  // stalled write must not reach tx
      rdy = 1'b1;
      total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL stall_tx got=%b exp=0", uart_tx_valid); end
      bus(32'h30004, 1'b0, 8'h00);
      total++; if (mem_rdata !== 8'd105) begin bad++; $display("FAIL cnt_frozen got=%0d exp=105", mem_rdata); end
   endtask

   task automatic test_rx();
      do_reset();
      uart_rx_valid = 1'b1;
      uart_rx_data = 8'h31; step();
      uart_rx_data = 8'h32; step();
      uart_rx_valid = 1'b0;
      bus(32'h30000, 1'b0, 8'h00);
      total++; if (mem_rdata !== 8'h31) begin bad++; $display("FAIL rx_1 got=%h exp=31", mem_rdata); end
      bus(32'h30000, 1'b0, 8'h00);
      total++; if (mem_rdata !== 8'h32) begin bad++; $display("FAIL rx_2 got=%h exp=32", mem_rdata); end
      bus(32'h30000, 1'b0, 8'h00);
      total++; if (mem_rdata !== 8'h00) begin bad++; $display("FAIL rx_empty got=%h exp=00", mem_rdata); end
      uart_rx_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin uart_rx_data = 8'(8'h40 + i); step(); end
      uart_rx_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus(32'h30000, 1'b0, 8'h00);
         total++; if (mem_rdata !== ((i < 8) ? 8'(8'h40 + i) : 8'h00)) begin
            bad++; $display("FAIL rx_ovf[%0d] got=%h exp=%h", i, mem_rdata, (i < 8) ? 8'(8'h40 + i) : 8'h00); end
      end
   endtask

   task automatic test_stop();
      do_reset();
      bus(32'h30004, 1'b1, 8'hFF);
      total++; if (program_done !== 1'b1) begin bad++; $display("FAIL stop_done got=%b exp=1", program_done); end
      total++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h00) begin
         bad++; $display("FAIL stop_tx got=%b/%h exp=1/00", uart_tx_valid, uart_tx_data); end
      bus(32'h30000, 1'b1, 8'h55);
      uart_tx_ready = 1'b1; step(); uart_tx_ready = 1'b0;
      total++; if (uart_tx_data !== 8'h55 || program_done !== 1'b1) begin
         bad++; $display("FAIL stop_next got=%h/%b exp=55/1", uart_tx_data, program_done); end
      rst = 1'b1; step(); rst = 1'b0;
      total++; if ({uart_tx_valid, program_done, io_buffer_full, mem_rdata} !== 11'h0) begin
         bad++; $display("FAIL stop_reset got=%b/%b/%b/%h exp=0/0/0/00", uart_tx_valid, program_done, io_buffer_full, mem_rdata); end
      step();
      total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL stop_lost got=%b exp=0", uart_tx_valid); end
   endtask

   task automatic test_random();
      int op;
      do_reset();
      for (int i = 0; i < 16; i++) bus(32'(i), 1'b1, 8'($urandom));
      for (int n = 0; n < 2000; n++) begin
         op = $urandom_range(0, 9);
         rdy = ($urandom_range(0, 4) != 0);
         uart_tx_ready = ($urandom_range(0, 2) == 0);
         uart_rx_valid = ($urandom_range(0, 3) == 0);
         uart_rx_data = 8'($urandom);
         mem_wr = 1'b0;
         mem_wdata = 8'($urandom);
         case (op)
            0:       begin mem_a = 32'($urandom_range(0, 15)); mem_wr = 1'b1; end
            1, 2:    mem_a = 32'($urandom_range(0, 15));
            3, 4, 9: begin mem_a = 32'h30000; mem_wr = 1'b1; if ($urandom_range(0, 3) == 0) mem_wdata = 8'h00; end
            5:       mem_a = 32'h30000;
            6:       mem_a = 32'h30004 + 32'($urandom_range(0, 3));
            7:       mem_a = 32'h30001 + 32'($urandom_range(0, 2));
            default: begin mem_a = 32'h30005 + 32'($urandom_range(0, 2)); mem_wr = 1'b1; end
         endcase
         mem_a = mem_a | ($urandom & 32'hFFFC_0000);
         step();
         total++; if (mem_rdata !== m_rdata) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, mem_rdata, m_rdata); end
         total++; if (io_buffer_full !== m_full) begin bad++; $display("FAIL rnd_full n=%0d got=%b exp=%b", n, io_buffer_full, m_full); end
         total++; if (uart_tx_valid !== (m_tx.size() != 0)) begin bad++; $display("FAIL rnd_txv n=%0d got=%b exp=%b", n, uart_tx_valid, m_tx.size() != 0); end
         if (m_tx.size() != 0) begin
            total++; if (uart_tx_data !== m_tx[0]) begin bad++; $display("FAIL rnd_txd n=%0d got=%h exp=%h", n, uart_tx_data, m_tx[0]); end
         end
         total++; if (program_done !== m_done) begin bad++; $display("FAIL rnd_done n=%0d got=%b exp=%b", n, program_done, m_done); end
      end
      rdy = 1'b1; uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; mem_a = '0; mem_wr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ram();
      test_uart_tx();
      test_full();
      test_counter();
      test_rx();
      test_stop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
